// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Pixel-rate divider, h/v counters, registered sync and blanked colour pins.
module vga_timing_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter int   CLK_DIV   = 2,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0,
    parameter int   COLOR_W   = 1,
    parameter int   X_W       = 10,
    parameter int   Y_W       = 10
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iEnable,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic [COLOR_W-1:0] VGA_RED,
    output logic [COLOR_W-1:0] VGA_GREEN,
    output logic [COLOR_W-1:0] VGA_BLUE,
    output logic               VGA_HSYNC,
    output logic               VGA_VSYNC,
    output logic [X_W-1:0]     oX,
    output logic [Y_W-1:0]     oY,
    output logic               oVisible,
    output logic               oPixelTick,
    output logic               oLineStart,
    output logic               oFrameStart
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);

    // One extra bit so sync-end bounds equal to the total still fit.
    localparam logic [X_W:0] X_VIS   = (X_W+1)'(H_VISIBLE);
    localparam logic [X_W:0] X_HS_LO = (X_W+1)'(H_VISIBLE + H_FRONT);
    localparam logic [X_W:0] X_HS_HI = (X_W+1)'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [Y_W:0] Y_VIS   = (Y_W+1)'(V_VISIBLE);
    localparam logic [Y_W:0] Y_VS_LO = (Y_W+1)'(V_VISIBLE + V_FRONT);
    localparam logic [Y_W:0] Y_VS_HI = (Y_W+1)'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0]   div_q, div_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] grn_q, grn_d;
    logic [COLOR_W-1:0] blu_q, blu_d;

    logic live;
    logic tick;
    logic vis;
    logic h_act;
    logic v_act;

    assign live  = Reset & iEnable;
    assign tick  = live && (div_q == DIV_LAST);
    assign vis   = ({1'b0, x_q} < X_VIS) && ({1'b0, y_q} < Y_VIS);
    assign h_act = ({1'b0, x_q} >= X_HS_LO) && ({1'b0, x_q} < X_HS_HI);
    assign v_act = ({1'b0, y_q} >= Y_VS_LO) && ({1'b0, y_q} < Y_VS_HI);

    always_comb begin
        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        red_d = red_q;
        grn_d = grn_q;
        blu_d = blu_q;
        if (!iEnable) begin
            div_d = '0;
            x_d   = '0;
            y_d   = '0;
            hs_d  = ~HSYNC_POL;
            vs_d  = ~VSYNC_POL;
            red_d = '0;
            grn_d = '0;
            blu_d = '0;
        end else if (tick) begin
            div_d = '0;
            hs_d  = h_act ? HSYNC_POL : ~HSYNC_POL;
            vs_d  = v_act ? VSYNC_POL : ~VSYNC_POL;
            red_d = vis ? iRed : '0;
            grn_d = vis ? iGreen : '0;
            blu_d = vis ? iBlue : '0;
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
            end else begin
                x_d = x_q + X_W'(1);
            end
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
            hs_q  <= ~HSYNC_POL;
            vs_q  <= ~VSYNC_POL;
            red_q <= '0;
            grn_q <= '0;
            blu_q <= '0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            red_q <= red_d;
            grn_q <= grn_d;
            blu_q <= blu_d;
        end
    end

    assign VGA_RED     = red_q;
    assign VGA_GREEN   = grn_q;
    assign VGA_BLUE    = blu_q;
    assign VGA_HSYNC   = hs_q;
    assign VGA_VSYNC   = vs_q;
    assign oX          = x_q;
    assign oY          = y_q;
    assign oVisible    = vis;
    assign oPixelTick  = tick;
    // divider at 0 marks the first Clock of every pixel period
    assign oLineStart  = live && (div_q == '0) && (x_q == '0);
    assign oFrameStart = oLineStart && (y_q == '0);
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for two small-raster instances
// (CLK_DIV=1 with low syncs, CLK_DIV=3 with high syncs).
module tb_vga_timing_gen;
    localparam int HV = 8, HF = 2, HS = 2, HB = 2;
    localparam int VV = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int DA = 1;
    localparam int DB = 3;

    typedef struct {
        int div;
        int x;
        int y;
        bit hs;
        bit vs;
        bit r;
        bit g;
        bit b;
    } ms_t;

    logic Clock;
    logic Reset;
    logic iEnable;

    logic a_red, a_grn, a_blu, a_vr, a_vg, a_vb, a_hs, a_vs;
    logic [3:0] a_x;
    logic [2:0] a_y;
    logic a_vis, a_tk, a_ls, a_fs;

    logic b_red, b_grn, b_blu, b_vr, b_vg, b_vb, b_hs, b_vs;
    logic [3:0] b_x;
    logic [2:0] b_y;
    logic b_vis, b_tk, b_ls, b_fs;

    assign a_red = a_x[0];
    assign a_grn = 1'b1;
    assign b_red = b_x[0];
    assign b_grn = 1'b1;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(DA), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
        .COLOR_W(1), .X_W(4), .Y_W(3)
    ) dut_a (
        .Clock(Clock), .Reset(Reset), .iEnable(iEnable),
        .iRed(a_red), .iGreen(a_grn), .iBlue(a_blu),
        .VGA_RED(a_vr), .VGA_GREEN(a_vg), .VGA_BLUE(a_vb),
        .VGA_HSYNC(a_hs), .VGA_VSYNC(a_vs),
        .oX(a_x), .oY(a_y), .oVisible(a_vis),
        .oPixelTick(a_tk), .oLineStart(a_ls), .oFrameStart(a_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(DB), .HSYNC_POL(1'b1), .VSYNC_POL(1'b1),
        .COLOR_W(1), .X_W(4), .Y_W(3)
    ) dut_b (
        .Clock(Clock), .Reset(Reset), .iEnable(iEnable),
        .iRed(b_red), .iGreen(b_grn), .iBlue(b_blu),
        .VGA_RED(b_vr), .VGA_GREEN(b_vg), .VGA_BLUE(b_vb),
        .VGA_HSYNC(b_hs), .VGA_VSYNC(b_vs),
        .oX(b_x), .oY(b_y), .oVisible(b_vis),
        .oPixelTick(b_tk), .oLineStart(b_ls), .oFrameStart(b_fs)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    ms_t qa[$];
    ms_t qb[$];
    ms_t sa, sb;
    int  n_chk, n_fail;
    bit  win;
    int  w_ag, w_ahs, w_avs, w_afs, w_atk;
    int  w_bhs, w_bvs, w_bfs, w_btk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic ms_t m_reset(input bit hp, input bit vp);
        ms_t s;
        s.div = 0; s.x = 0; s.y = 0;
        s.hs = !hp; s.vs = !vp;
        s.r = 0; s.g = 0; s.b = 0;
        return s;
    endfunction

    function automatic ms_t m_step(input ms_t s, input int cdiv,
                                   input bit hp, input bit vp,
                                   input bit rst, input bit en,
                                   input bit r, input bit g, input bit b);
        ms_t n;
        bit  vis;
        n = s;
        if (!rst || !en) return m_reset(hp, vp);
        if (s.div != cdiv - 1) begin
            n.div = s.div + 1;
            return n;
        end
        n.div = 0;
        n.hs = (s.x >= HV + HF && s.x < HV + HF + HS) ? hp : !hp;
        n.vs = (s.y >= VV + VF && s.y < VV + VF + VS) ? vp : !vp;
        vis = (s.x < HV) && (s.y < VV);
        n.r = vis & r;
        n.g = vis & g;
        n.b = vis & b;
        if (s.x == HT - 1) begin
            n.x = 0;
            n.y = (s.y == VT - 1) ? 0 : s.y + 1;
        end else begin
            n.x = s.x + 1;
        end
        return n;
    endfunction

    task automatic cmp(input string p, input ms_t s, input int cdiv,
                       input bit live, input int x, input int y,
                       input bit hs, input bit vs, input bit r,
                       input bit g, input bit b, input bit vis,
                       input bit tk, input bit ls, input bit fs);
        bit els;
        els = live && s.div == 0 && s.x == 0;
        chk({p, ".x"}, x, s.x);
        chk({p, ".y"}, y, s.y);
        chk({p, ".hs"}, int'(hs), int'(s.hs));
        chk({p, ".vs"}, int'(vs), int'(s.vs));
        chk({p, ".r"}, int'(r), int'(s.r));
        chk({p, ".g"}, int'(g), int'(s.g));
        chk({p, ".b"}, int'(b), int'(s.b));
        chk({p, ".vis"}, int'(vis), int'(s.x < HV && s.y < VV));
        chk({p, ".tick"}, int'(tk), int'(live && s.div == cdiv - 1));
        chk({p, ".ls"}, int'(ls), int'(els));
        chk({p, ".fs"}, int'(fs), int'(els && s.y == 0));
    endtask

    task automatic cycle(input bit rst, input bit en);
        @(negedge Clock);
        sa = qa.pop_front();
        sb = qb.pop_front();
        Reset   = rst;
        iEnable = en;
        a_blu   = 1'($urandom);
        b_blu   = 1'($urandom);
        if (!rst) begin
            sa = m_reset(1'b0, 1'b0);
            sb = m_reset(1'b1, 1'b1);
        end
        #1;
        cmp("A", sa, DA, rst && en, int'(a_x), int'(a_y), a_hs, a_vs,
            a_vr, a_vg, a_vb, a_vis, a_tk, a_ls, a_fs);
        cmp("B", sb, DB, rst && en, int'(b_x), int'(b_y), b_hs, b_vs,
            b_vr, b_vg, b_vb, b_vis, b_tk, b_ls, b_fs);
        if (win) begin
            w_ag  += int'(a_vg);
            w_ahs += int'(!a_hs);
            w_avs += int'(!a_vs);
            w_afs += int'(a_fs);
            w_atk += int'(a_tk);
            w_bhs += int'(b_hs);
            w_bvs += int'(b_vs);
            w_bfs += int'(b_fs);
            w_btk += int'(b_tk);
        end
        qa.push_back(m_step(sa, DA, 1'b0, 1'b0, rst, en, sa.x[0], 1'b1, a_blu));
        qb.push_back(m_step(sb, DB, 1'b1, 1'b1, rst, en, sb.x[0], 1'b1, b_blu));
    endtask

    // 294 Clocks = 3 frames of A, 1 frame of B
    task automatic window(input string p);
        w_ag = 0; w_ahs = 0; w_avs = 0; w_afs = 0; w_atk = 0;
        w_bhs = 0; w_bvs = 0; w_bfs = 0; w_btk = 0;
        win = 1;
        repeat (HT * VT * DB) cycle(1'b1, 1'b1);
        win = 0;
        chk({p, ".a_green_hi"}, w_ag, 3 * HV * VV);
        chk({p, ".a_hs_lo"}, w_ahs, 3 * HS * VT);
        chk({p, ".a_vs_lo"}, w_avs, 3 * VS * HT);
        chk({p, ".a_frames"}, w_afs, 3);
        chk({p, ".a_ticks"}, w_atk, HT * VT * DB);
        chk({p, ".b_hs_hi"}, w_bhs, HS * DB * VT);
        chk({p, ".b_vs_hi"}, w_bvs, VS * HT * DB);
        chk({p, ".b_frames"}, w_bfs, 1);
        chk({p, ".b_ticks"}, w_btk, HT * VT);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_fail = 0; win = 0;
        Reset = 1'b1; iEnable = 1'b0; a_blu = 1'b0; b_blu = 1'b0;
        qa.push_back(m_reset(1'b0, 1'b0));
        qb.push_back(m_reset(1'b1, 1'b1));
        #1 Reset = 1'b0;

        repeat (3) cycle(1'b0, 1'b1);
        chk("rst.a_hs", int'(a_hs), 1);
        chk("rst.b_hs", int'(b_hs), 0);
        chk("rst.b_vs", int'(b_vs), 0);
        chk("rst.a_tick", int'(a_tk), 0);
        repeat (2) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        chk("rel.a_fs", int'(a_fs), 1);
        chk("rel.b_ls", int'(b_ls), 1);
        chk("rel.a_tick", int'(a_tk), 1);
        chk("rel.b_tick", int'(b_tk), 0);

        repeat (300) cycle(1'b1, 1'b1);
        window("w1");

        for (int i = 0; i < 200 && !(qa[0].x == 5 && qa[0].y == 2); i++)
            cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        chk("drop.a_x", int'(a_x), 5);
        chk("drop.a_y", int'(a_y), 2);
        cycle(1'b1, 1'b0);
        chk("dis.a_x", int'(a_x), 0);
        chk("dis.a_y", int'(a_y), 0);
        chk("dis.a_hs", int'(a_hs), 1);
        chk("dis.b_hs", int'(b_hs), 0);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        chk("reen.a_fs", int'(a_fs), 1);
        chk("reen.b_fs", int'(b_fs), 1);
        cycle(1'b1, 1'b1);
        chk("reen2.a_x", int'(a_x), 1);
        chk("reen2.b_fs", int'(b_fs), 0);

        for (int i = 0; i < 200 && !(qa[0].x == 3 && qa[0].y == 5); i++)
            cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        chk("pre.a_vs", int'(a_vs), 0);
        @(posedge Clock);
        #2 Reset = 1'b0;
        #1;
        chk("async.a_vs", int'(a_vs), 1);
        chk("async.a_x", int'(a_x), 0);
        chk("async.a_y", int'(a_y), 0);
        chk("async.a_red", int'(a_vr), 0);
        chk("async.a_tick", int'(a_tk), 0);
        chk("async.b_vs", int'(b_vs), 0);
        chk("async.b_x", int'(b_x), 0);
        qa.delete();
        qb.delete();
        qa.push_back(m_reset(1'b0, 1'b0));
        qb.push_back(m_reset(1'b1, 1'b1));
        repeat (2) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        chk("resume.a_fs", int'(a_fs), 1);
        repeat (300) cycle(1'b1, 1'b1);
        window("w2");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480 sync logic behind MiniAlu's VGA_RED/GREEN/BLUE/HSYNC/VSYNC outputs.
- Derives a pixel-rate enable from the system Clock and runs horizontal and vertical counters.
- Produces registered sync, blanking-gated RGB, pixel coordinates and frame/line strobes.
- Sits between the pixel-source logic (framebuffer/ALU-driven painter) and the board VGA pins.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)
CLK_DIV, 2, Clock cycles per pixel (>=1)
HSYNC_POL, 0, active level of VGA_HSYNC
VSYNC_POL, 0, active level of VGA_VSYNC
COLOR_W, 1, bits per colour channel
X_W, 10, width of oX (must hold H_TOTAL-1)
Y_W, 10, width of oY (must hold V_TOTAL-1)

Ports:
Clock  in  1  system clock
Reset  in  1  asynchronous, active-low reset
iEnable  in  1  run raster; low holds generator idle
iRed  in  COLOR_W  red for pixel at oX,oY
iGreen  in  COLOR_W  green for pixel at oX,oY
iBlue  in  COLOR_W  blue for pixel at oX,oY
VGA_RED  out  COLOR_W  registered red, zero in blanking
VGA_GREEN  out  COLOR_W  registered green, zero in blanking
VGA_BLUE  out  COLOR_W  registered blue, zero in blanking
VGA_HSYNC  out  1  registered horizontal sync
VGA_VSYNC  out  1  registered vertical sync
oX  out  X_W  current horizontal counter
oY  out  Y_W  current vertical counter
oVisible  out  1  oX<H_VISIBLE and oY<V_VISIBLE
oPixelTick  out  1  one-Clock pulse when counters advance
oLineStart  out  1  one-Clock pulse, first Clock of oX==0
oFrameStart  out  1  one-Clock pulse, first Clock of (0,0)

Behaviour:
- H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Reset low (async, any time, including mid-frame): divider=0, oX=0, oY=0, colour outputs 0, VGA_HSYNC=~HSYNC_POL, VGA_VSYNC=~VSYNC_POL, all strobes 0.
- Reset release: oFrameStart/oLineStart asserted in the first Clock with iEnable high.
- Divider counts 0..CLK_DIV-1 while iEnable=1.
- oPixelTick=1 in the Clock where divider==CLK_DIV-1. With CLK_DIV=1, oPixelTick is high every Clock.
- On tick, oX increments. At H_TOTAL-1 it wraps to 0 and oY increments. oY wraps V_TOTAL-1 -> 0 on the same tick that oX wraps.
- On the same tick, output registers load from the pre-increment counter values:
  - VGA_HSYNC = HSYNC_POL when H_VISIBLE+H_FRONT <= oX < H_VISIBLE+H_FRONT+H_SYNC, else ~HSYNC_POL.
  - VGA_VSYNC = VSYNC_POL when V_VISIBLE+V_FRONT <= oY < V_VISIBLE+V_FRONT+V_SYNC, else ~VSYNC_POL.
  - Colour outputs = iRed/iGreen/iBlue if oVisible, else 0.
- Pixel source contract: iRed/iGreen/iBlue must be valid for (oX,oY) by the tick ending that pixel. Pins therefore lag the coordinates by exactly one pixel period, with sync and colour mutually aligned.
- Between ticks, all output registers hold their value.
- oVisible is combinational from the counters.
- oLineStart/oFrameStart are one-Clock pulses in the first Clock of the new pixel period (the Clock after the wrapping tick), never repeated within that period.
- iEnable low (any time, mid-line included), effective next Clock: divider, oX, oY cleared; syncs inactive; colour 0; strobes 0.
- iEnable rising: raster restarts at (0,0); oFrameStart and oLineStart pulse in the first enabled Clock.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1; no out-of-range state is reachable.

Test Plan:
- Default params, Reset low 100 ns then high, iEnable=1, 10 ns Clock -> VGA_HSYNC period 1600 Clocks, low for 192 Clocks; VGA_VSYNC period 840000 Clocks, low 3200 Clocks; first hsync falling edge 1313 Clocks after first oFrameStart (656 ticks x2 + 1 register Clock).
- Small params (H 8/2/2/2, V 4/1/1/1, CLK_DIV=1), iRed=1 constant -> VGA_RED high for exactly 8 consecutive Clocks per 14-Clock line, and only on lines 0..3 of each 7-line frame; oFrameStart once per 98 Clocks.
- Small params, HSYNC_POL=1, VSYNC_POL=1 -> syncs idle low, pulse high with the same widths; reset value of both syncs is 0.
- iRed driven as oX[0] -> VGA_RED pattern is oX[0] delayed one pixel; 0 throughout blanking.
- iEnable dropped at oX=5, oY=2 for 3 Clocks, then raised -> next Clock oX=oY=0, syncs inactive; on re-enable oFrameStart pulses once and timing restarts from (0,0).
- Reset asserted low mid-vsync -> same Clock (asynchronous) VGA_VSYNC returns to ~VSYNC_POL, colour 0, oX=oY=0; normal frame resumes after release.
